// File: rtl/dmem_ctrl.sv
// Two-port sequencer/arbiter in front of a byte-addressed 32-bit data RAM.
// Handles sized loads with extension, read-modify-write sub-word stores and misalignment rejection.
module dmem_ctrl #(
    parameter int ADDR_W     = 10,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic              p0_sext,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic              p1_sext,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [31:0]       p1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: pN_req is held high until pN_done; pN_gnt and pN_done are single-cycle pulses,
    // and pN_err/pN_rdata are meaningful in the pN_done cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t            state;
    logic              cur_port;
    logic              l_we;
    logic              l_sext;
    logic              l_err;
    logic [1:0]        l_size;
    logic [31:0]       l_wdata;
    logic [31:0]       res;
    logic              rr_ptr;

    logic              win;
    logic              w_we;
    logic              w_sext;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Only the lanes covered by the access size are looked at, so undefined upper lanes are harmless.
    function automatic logic [31:0] extend(input logic [31:0] rd, input logic [1:0] size,
                                           input logic sext);
        logic [31:0] v;
        v = rd;
        if (size == 2'b00)
            v = {{24{sext & rd[7]}}, rd[7:0]};
        else if (size == 2'b01)
            v = {{16{sext & rd[15]}}, rd[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size);
        return (size == 2'b00) ? {old[31:8], wd[7:0]} : {old[31:16], wd[15:0]};
    endfunction

    always_comb begin
        win = 1'b0;
        if (PRIO_FIXED)
            win = !p0_req;
        else if (p0_req && p1_req)
            win = rr_ptr;
        else
            win = !p0_req;
    end

    assign w_we      = win ? p1_we    : p0_we;
    assign w_sext    = win ? p1_sext  : p0_sext;
    assign w_size    = win ? p1_size  : p0_size;
    assign w_addr    = win ? p1_addr  : p0_addr;
    assign w_wdata   = win ? p1_wdata : p0_wdata;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cur_port  <= 1'b0;
            l_we      <= 1'b0;
            l_sext    <= 1'b0;
            l_err     <= 1'b0;
            l_size    <= 2'b00;
            l_wdata   <= 32'h0;
            res       <= 32'h0;
            rr_ptr    <= 1'b0;
            p0_gnt    <= 1'b0;
            p0_done   <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= 32'h0;
            p1_gnt    <= 1'b0;
            p1_done   <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= 32'h0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
        end else begin
            p0_gnt  <= 1'b0;
            p0_done <= 1'b0;
            p0_err  <= 1'b0;
            p1_gnt  <= 1'b0;
            p1_done <= 1'b0;
            p1_err  <= 1'b0;
            ram_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        cur_port <= win;
                        l_we     <= w_we;
                        l_sext   <= w_sext;
                        l_size   <= w_size;
                        l_wdata  <= w_wdata;
                        l_err    <= 1'b0;
                        ram_addr <= w_addr;
                        rr_ptr   <= ~win;
                        p0_gnt   <= ~win;
                        p1_gnt   <= win;
                        // An aligned word store writes during the ACCESS cycle itself.
                        if (w_we && w_size == 2'b10 && w_addr[1:0] == 2'b00) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= w_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (misaligned(l_size, ram_addr[1:0])) begin
                        l_err <= 1'b1;
                    end else if (!l_we) begin
                        res <= extend(ram_rdata, l_size, l_sext);
                    end else if (l_size != 2'b10) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= merge(ram_rdata, l_wdata, l_size);
                        state     <= MERGE_WR;
                    end
                end
                MERGE_WR: begin
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    if (cur_port) begin
                        p1_done <= 1'b1;
                        p1_err  <= l_err;
                        if (!l_we && !l_err) p1_rdata <= res;
                    end else begin
                        p0_done <= 1'b1;
                        p0_err  <= l_err;
                        if (!l_we && !l_err) p0_rdata <= res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, reset and arbitration sequences,
// and random traffic checked against a byte-array memory model.
module tb_dmem_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          p0_req, p0_we, p0_sext, p1_req, p1_we, p1_sext;
    logic [1:0]    p0_size, p1_size;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [1:0]    dbg_state;

    logic          f_p0_req, f_p1_req;
    logic          f_p0_gnt, f_p0_done, f_p0_err, f_p1_gnt, f_p1_done, f_p1_err;
    logic [31:0]   f_p0_rdata, f_p1_rdata, f_ram_wdata;
    logic          f_ram_we;
    logic [AW-1:0] f_ram_addr;
    logic [1:0]    f_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_ctrl #(.ADDR_W(AW), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sext(p0_sext),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sext(p1_sext),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state)
    );

    dmem_ctrl #(.ADDR_W(AW), .PRIO_FIXED(1'b1)) dut_fixed (
        .clk(clk), .rstn(rstn),
        .p0_req(f_p0_req), .p0_we(1'b0), .p0_size(2'b10), .p0_sext(1'b0),
        .p0_addr(10'h000), .p0_wdata(32'h0), .p0_gnt(f_p0_gnt), .p0_done(f_p0_done),
        .p0_err(f_p0_err), .p0_rdata(f_p0_rdata),
        .p1_req(f_p1_req), .p1_we(1'b0), .p1_size(2'b10), .p1_sext(1'b0),
        .p1_addr(10'h004), .p1_wdata(32'h0), .p1_gnt(f_p1_gnt), .p1_done(f_p1_done),
        .p1_err(f_p1_err), .p1_rdata(f_p1_rdata),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(32'h0),
        .dbg_state(f_dbg_state)
    );

    // RAM model: bytes beyond the top of the array read as 0 and are never written.
    logic [7:0]  mem [0:1023];
    logic        mem_clr;
    logic [10:0] a0, a1, a2, a3;
    assign a0 = {1'b0, ram_addr};
    assign a1 = a0 + 11'd1;
    assign a2 = a0 + 11'd2;
    assign a3 = a0 + 11'd3;
    assign ram_rdata = {a3[10] ? 8'h00 : mem[a3[9:0]], a2[10] ? 8'h00 : mem[a2[9:0]],
                        a1[10] ? 8'h00 : mem[a1[9:0]], mem[a0[9:0]]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[a0[9:0]] <= ram_wdata[7:0];
            if (!a1[10]) mem[a1[9:0]] <= ram_wdata[15:8];
            if (!a2[10]) mem[a2[9:0]] <= ram_wdata[23:16];
            if (!a3[10]) mem[a3[9:0]] <= ram_wdata[31:24];
        end
    end

    // Reference model: the memory as an array of bytes, accesses as byte counts.
    logic [7:0] ref_mem [0:1023];

    function automatic bit ref_misaligned(input int addr, input int size);
        if (size == 3) return 1'b1;
        return (addr % (1 << size)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int addr, input int size, input bit sext);
        int n;
        longint v;
        n = 1 << size;
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[addr + k]) << (8 * k);
        if (sext && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic ref_store(input int addr, input int size, input logic [31:0] wdata);
        for (int k = 0; k < (1 << size); k++) ref_mem[addr + k] = wdata[8 * k +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit we, input logic [1:0] size, input bit sext,
                         input logic [9:0] addr, input logic [31:0] wdata, input bit req);
        if (!port) begin
            p0_we = we; p0_size = size; p0_sext = sext; p0_addr = addr; p0_wdata = wdata;
            p0_req = req;
        end else begin
            p1_we = we; p1_size = size; p1_sext = sext; p1_addr = addr; p1_wdata = wdata;
            p1_req = req;
        end
    endtask

    // Runs one access from the cycle after a posedge; latency is counted in edges from gnt to done.
    task automatic do_access(input bit port, input bit we, input logic [1:0] size, input bit sext,
                             input logic [9:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd, output bit err, output int gnt_wait,
                             output int lat, output int we_cnt, output int stray);
        bit g, d;
        gnt_wait = -1; lat = -1; we_cnt = 0; stray = 0; rd = 32'h0; err = 1'b0;
        drive(port, we, size, sext, addr, wdata, 1'b1);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            g = port ? p1_gnt : p0_gnt;
            d = port ? p1_done : p0_done;
            we_cnt += int'(ram_we);
            stray += port ? int'(p0_gnt | p0_done | p0_err) : int'(p1_gnt | p1_done | p1_err);
            if (g && gnt_wait < 0) gnt_wait = e;
            if (d && gnt_wait >= 0) begin
                lat = e - gnt_wait;
                rd  = port ? p1_rdata : p0_rdata;
                err = port ? p1_err : p0_err;
                break;
            end
        end
        drive(port, we, size, sext, addr, wdata, 1'b0);
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          sext;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t        tbl [17];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd [2];
        bit          err, found;
        int          gw, lat, wec, stray, both, f0, f1, diff;

        mem_clr = 1'b1;
        f_p0_req = 1'b0;
        f_p1_req = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0, 1'b0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        // Reset state, both while held and after release.
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        check("rst_held_ctrl", {25'h0, p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, ram_we}, 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ctrl", {25'h0, p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, ram_we}, 32'h0);
        check("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);

        // Directed vectors, all on port 0.
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 10'h011, 32'h000000AA, 32'hDEADBEEF, 1'b0, 3, 1};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'hDEADAAEF, 1'b0, 2, 0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 10'h011, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 10'h011, 32'h0,        32'h000000AA, 1'b0, 2, 0};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 10'h012, 32'h00008001, 32'h000000AA, 1'b0, 3, 1};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 10'h012, 32'h0,        32'hFFFF8001, 1'b0, 2, 0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 10'h012, 32'h0,        32'hFFFF8001, 1'b1, 2, 0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 10'h013, 32'h0,        32'hFFFF8001, 1'b1, 2, 0};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 10'h012, 32'h12345678, 32'hFFFF8001, 1'b1, 2, 0};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 10'h014, 32'h12345678, 32'hFFFF8001, 1'b1, 2, 0};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 10'h3FF, 32'h0000005C, 32'hFFFF8001, 1'b0, 3, 1};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 10'h3FF, 32'h0,        32'h0000005C, 1'b0, 2, 0};
        tbl[14] = '{1'b0, 2'd1, 1'b0, 10'h010, 32'h0,        32'h0000AAEF, 1'b0, 2, 0};
        tbl[15] = '{1'b0, 2'd1, 1'b1, 10'h010, 32'h0,        32'hFFFFAAEF, 1'b0, 2, 0};
        tbl[16] = '{1'b0, 2'd0, 1'b1, 10'h3FF, 32'h0,        32'h0000005C, 1'b0, 2, 0};

        for (int i = 0; i < 17; i++) begin
            do_access(1'b0, tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wdata,
                      rd, err, gw, lat, wec, stray);
            if (tbl[i].we && !tbl[i].exp_err) ref_store(int'(tbl[i].addr), int'(tbl[i].size), tbl[i].wdata);
            check($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
            check($sformatf("v%0d_gnt_wait", i), gw, 1);
            check($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
            check($sformatf("v%0d_ram_we_cycles", i), wec, tbl[i].exp_we);
            check($sformatf("v%0d_other_port", i), stray, 0);
        end

        // Reset asserted while a byte store sits in its write cycle.
        do_access(1'b0, 1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344, rd, err, gw, lat, wec, stray);
        ref_store(32'h20, 2, 32'h11223344);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 10'h020, 32'h00000077, 1'b1);
        @(posedge clk);
        #1;
        check("abort_gnt", {31'h0, p0_gnt}, 32'h1);
        @(posedge clk);
        #1;
        check("abort_merge_we", {31'h0, ram_we}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_we_dropped", {31'h0, ram_we}, 32'h0);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 10'h020, 32'h00000077, 1'b0);
        @(posedge clk);
        #1;
        check("abort_no_done", {31'h0, p0_done}, 32'h0);
        rstn = 1'b1;
        check("abort_word_kept", {mem[35], mem[34], mem[33], mem[32]},
              {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]});
        check("abort_state", {30'h0, dbg_state}, 32'h0);

        // Both ports requesting continuously: round-robin alternates from port 0, fixed always picks port 0.
        drive(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 10'h014, 32'h0, 1'b1);
        f_p0_req = 1'b1;
        f_p1_req = 1'b1;
        both = 0; f0 = 0; f1 = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (p0_gnt) got_q.push_back(32'd0);
            if (p1_gnt) got_q.push_back(32'd1);
            if (p0_gnt && p1_gnt) both++;
            f0 += int'(f_p0_gnt);
            f1 += int'(f_p1_gnt);
        end
        drive(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 10'h014, 32'h0, 1'b0);
        f_p0_req = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i % 2));
        check("rr_grant_count", got_q.size(), 14);
        check("rr_double_grant", both, 0);
        for (int i = 0; i < 6; i++) begin
            if (got_q.size() > 0) check($sformatf("rr_grant%0d", i), got_q.pop_front(), exp_q.pop_front());
            else check($sformatf("rr_grant%0d", i), 32'hFFFFFFFF, exp_q.pop_front());
        end
        check("fixed_p0_grants", f0, 14);
        check("fixed_p1_grants", f1, 0);
        found = 1'b0;
        for (int e = 0; e < 10 && !found; e++) begin
            @(posedge clk);
            #1;
            if (f_p1_gnt) found = 1'b1;
        end
        f_p1_req = 1'b0;
        check("fixed_p1_when_p0_idle", {31'h0, found}, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        do_access(1'b0, 1'b0, 2'd2, 1'b0, 10'h020, 32'h0, rd, err, gw, lat, wec, stray);
        check("abort_reload", rd, ref_load(32'h20, 2, 1'b0));

        // Random single-port traffic against the byte-array model.
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        for (int t = 0; t < 200; t++) begin
            bit          port, we, sext, e_err;
            int          size, n, addr, e_lat, e_we;
            logic [31:0] wdata;
            port  = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            sext  = 1'($urandom_range(0, 1));
            size  = $urandom_range(0, 3);
            wdata = $urandom;
            addr  = ($urandom_range(0, 7) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 63);
            n     = (size == 3) ? 1 : (1 << size);
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
            e_err = ref_misaligned(addr, size);
            e_lat = (e_err || !we || size == 2) ? 2 : 3;
            e_we  = (we && !e_err) ? 1 : 0;
            if (!we && !e_err) exp_rd[port] = ref_load(addr, size, sext);
            if (we && !e_err) ref_store(addr, size, wdata);
            do_access(port, we, 2'(size), sext, 10'(addr), wdata, rd, err, gw, lat, wec, stray);
            check($sformatf("rnd%0d_rdata", t), rd, exp_rd[port]);
            check($sformatf("rnd%0d_err", t), {31'h0, err}, {31'h0, e_err});
            check($sformatf("rnd%0d_latency", t), lat, e_lat);
            check($sformatf("rnd%0d_ram_we_cycles", t), wec, e_we);
            check($sformatf("rnd%0d_other_port", t), stray, 0);
        end

        diff = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image_diff_bytes", diff, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
